dispense_source_arbiter: RTL and testbench

- Parametrised successor to the controller/maintenance input selector in the chip dispenser.
- Selects one of NUM_SRC command sources (index 0 = customer controller, index 1 = maintenance, higher indices = future panels).
- Converts that source's start level into a single registered start pulse with a registered command.
- Holds the selection locked until the dispenser reports completion, and flags a timeout if completion never arrives.

---
 rtl/dispense_source_arbiter_pkg.sv | 19 +
 rtl/dispense_source_arbiter_start_edge_detect.sv | 24 ++
 rtl/dispense_source_arbiter.sv | 118 +++++++++++
 tb/tb_dispense_source_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dispense_source_arbiter_pkg.sv
// Shared dispenser definitions: arbiter state encoding, source indices and chip command codes.
package dispenser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } dispState_t;

    localparam int SRC_CONTROLLER  = 0;
    localparam int SRC_MAINTENANCE = 1;

    localparam logic [1:0] CHIP_5   = 2'd0;
    localparam logic [1:0] CHIP_10  = 2'd1;
    localparam logic [1:0] CHIP_25  = 2'd2;
    localparam logic [1:0] CHIP_100 = 2'd3;

endpackage

// File: rtl/dispense_source_arbiter_start_edge_detect.sv
// Registered rising-edge detector for the per-source start levels.
module start_edge_detect #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prevLevel;

    // History resets to ones so a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevLevel <= '1;
            rise      <= '0;
        end else begin
            prevLevel <= level;
            rise      <= level & ~prevLevel;
        end
    end

endmodule

// File: rtl/dispense_source_arbiter.sv
// Picks one command source, turns its start edge into a single start pulse and
// holds the selection until the dispenser completes or times out.
//
// state | meaning
// IDLE  | waiting for a start edge on the selected source
// ISSUE | one-cycle start pulse and ack to the dispenser
// WAIT  | dispense in progress, timeout counter running
// ERR   | dispenser never completed; sticky until err_clr
module dispense_source_arbiter
    import dispenser_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 1,
    parameter int CMD_W   = 2,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [NUM_SRC-1:0]       src_start,
    input  logic [NUM_SRC*CMD_W-1:0] src_cmd,
    input  logic                     disp_done,
    input  logic                     err_clr,
    output logic                     start_out,
    output logic [CMD_W-1:0]         cmd_out,
    output logic [SEL_W-1:0]         active_src,
    output logic                     busy,
    output logic [NUM_SRC-1:0]       src_ack,
    output logic                     timeout_err
);

    localparam int SEL_N = 1 << SEL_W;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    dispState_t state, nextState;

    logic [NUM_SRC-1:0]     srcRise;
    logic [SEL_N-1:0]       riseExt;
    logic [SEL_N*CMD_W-1:0] cmdExt;
    logic                   selRise;
    logic [TMO_W-1:0]       tmoCnt;

    logic                   startNext;
    logic                   busyNext;
    logic                   errNext;
    logic                   issueNow;
    logic [SEL_W-1:0]       activeNext;
    logic [CMD_W-1:0]       cmdNext;
    logic [NUM_SRC-1:0]     ackNext;

    start_edge_detect #(
        .WIDTH(NUM_SRC)
    ) u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .level(src_start),
        .rise (srcRise)
    );

    // Pad to the full src_sel range so out-of-range indices read as "no edge".
    always_comb begin
        riseExt = '0;
        riseExt[NUM_SRC-1:0] = srcRise;
        cmdExt = '0;
        cmdExt[NUM_SRC*CMD_W-1:0] = src_cmd;
        selRise = riseExt[src_sel];
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (selRise) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT: begin
                if (disp_done) nextState = IDLE;
                else if (tmoCnt >= TMO_LAST) nextState = ERR;
            end
            ERR:     if (err_clr) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered with it.
    always_comb begin
        startNext  = (nextState == ISSUE);
        busyNext   = (nextState == ISSUE) || (nextState == WAIT);
        errNext    = (nextState == ERR);
        issueNow   = (state == IDLE) && startNext;
        activeNext = issueNow ? src_sel : active_src;
        cmdNext    = issueNow ? cmdExt[src_sel*CMD_W +: CMD_W] : cmd_out;
        ackNext    = startNext ? (NUM_SRC'(1) << activeNext) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tmoCnt      <= '0;
            start_out   <= 1'b0;
            cmd_out     <= '0;
            active_src  <= '0;
            busy        <= 1'b0;
            src_ack     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= nextState;
            start_out   <= startNext;
            cmd_out     <= cmdNext;
            active_src  <= activeNext;
            busy        <= busyNext;
            src_ack     <= ackNext;
            timeout_err <= errNext;
            if (nextState == ISSUE) tmoCnt <= '0;
            else if (state == ISSUE || state == WAIT) tmoCnt <= tmoCnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_dispense_source_arbiter.sv
// Scoreboard bench for dispense_source_arbiter: a 2-source default build and a 3-source build.
module tb_dispense_source_arbiter;

    typedef struct {
        int          cyc;
        logic [31:0] cmd;
        logic [31:0] act;
        logic [31:0] ack;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   nVectors = 0;
    int   nMiscompares = 0;
    int   issueCyc;

    logic       sel2, done2, clr2;
    logic [1:0] start2;
    logic [3:0] cmd2;
    logic       so2, as2, busy2, err2;
    logic [1:0] co2, ack2;

    logic [1:0] sel3;
    logic [2:0] start3;
    logic [5:0] cmd3;
    logic       done3, clr3;
    logic       so3, busy3, err3;
    logic [1:0] co3, as3;
    logic [2:0] ack3;

    exp_t q2[$];
    exp_t q3[$];
    exp_t e2, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dispense_source_arbiter dut2 (
        .clk(clk), .rst_n(rst_n), .src_sel(sel2), .src_start(start2), .src_cmd(cmd2),
        .disp_done(done2), .err_clr(clr2), .start_out(so2), .cmd_out(co2),
        .active_src(as2), .busy(busy2), .src_ack(ack2), .timeout_err(err2)
    );

    dispense_source_arbiter #(
        .NUM_SRC(3), .SEL_W(2), .CMD_W(2), .TMO_W(8), .TMO_CYC(200)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .src_sel(sel3), .src_start(start3), .src_cmd(cmd3),
        .disp_done(done3), .err_clr(clr3), .start_out(so3), .cmd_out(co3),
        .active_src(as3), .busy(busy3), .src_ack(ack3), .timeout_err(err3)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (so2) begin
                if (q2.size() == 0) checkVal("unexp_start2", 32'(so2), 0);
                else begin
                    e2 = q2.pop_front();
                    checkVal("lat2", cyc, e2.cyc);
                    checkVal("cmd2", 32'(co2), e2.cmd);
                    checkVal("act2", 32'(as2), e2.act);
                    checkVal("ack2", 32'(ack2), e2.ack);
                end
            end else checkVal("ack2_quiet", 32'(ack2), 0);
            if (so3) begin
                if (q3.size() == 0) checkVal("unexp_start3", 32'(so3), 0);
                else begin
                    e3 = q3.pop_front();
                    checkVal("lat3", cyc, e3.cyc);
                    checkVal("cmd3", 32'(co3), e3.cmd);
                    checkVal("act3", 32'(as3), e3.act);
                    checkVal("ack3", 32'(ack3), e3.ack);
                end
            end else checkVal("ack3_quiet", 32'(ack3), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sel2 = 1'b0; start2 = 2'b01; cmd2 = '0; done2 = 1'b0; clr2 = 1'b0;
        sel3 = 2'd0; start3 = '0; cmd3 = '0; done3 = 1'b0; clr3 = 1'b0;
        tick(3);
        checkVal("rst_start", 32'(so2), 0);
        checkVal("rst_cmd", 32'(co2), 0);
        checkVal("rst_act", 32'(as2), 0);
        checkVal("rst_busy", 32'(busy2), 0);
        checkVal("rst_ack", 32'(ack2), 0);
        checkVal("rst_err", 32'(err2), 0);
        rst_n = 1'b1;
        tick(5);
        checkVal("held_busy", 32'(busy2), 0);

        // first issue from the controller
        start2[0] = 1'b0;
        tick(2);
        cmd2[1:0] = 2'b10;
        start2[0] = 1'b1;
        q2.push_back('{cyc + 2, 32'd2, 32'd0, 32'd1});
        tick(4);
        checkVal("wait_busy", 32'(busy2), 1);

        // select change and maintenance edge while in WAIT are dropped
        sel2 = 1'b1;
        start2[1] = 1'b1;
        tick(1);
        start2[1] = 1'b0;
        tick(4);
        checkVal("wait_active", 32'(as2), 0);
        done2 = 1'b1;
        tick(1);
        done2 = 1'b0;
        tick(1);
        checkVal("done_busy", 32'(busy2), 0);
        checkVal("cmd_hold", 32'(co2), 2);

        // maintenance issue, then let it time out
        cmd2[3:2] = 2'b11;
        start2[1] = 1'b1;
        issueCyc = cyc + 2;
        q2.push_back('{issueCyc, 32'd3, 32'd1, 32'd2});
        while (cyc < issueCyc + 199) tick(1);
        checkVal("pre_tmo_err", 32'(err2), 0);
        checkVal("pre_tmo_busy", 32'(busy2), 1);
        tick(1);
        checkVal("tmo_err", 32'(err2), 1);
        checkVal("tmo_busy", 32'(busy2), 0);

        start2[1] = 1'b0;
        tick(2);
        start2[1] = 1'b1;
        tick(4);
        done2 = 1'b1;
        tick(1);
        done2 = 1'b0;
        tick(1);
        checkVal("err_sticky", 32'(err2), 1);
        clr2 = 1'b1;
        tick(1);
        clr2 = 1'b0;
        checkVal("clr_err", 32'(err2), 0);
        checkVal("clr_busy", 32'(busy2), 0);

        // done coincident with the last timeout cycle wins
        start2[1] = 1'b0;
        tick(2);
        cmd2[3:2] = 2'b01;
        start2[1] = 1'b1;
        issueCyc = cyc + 2;
        q2.push_back('{issueCyc, 32'd1, 32'd1, 32'd2});
        while (cyc < issueCyc + 199) tick(1);
        done2 = 1'b1;
        tick(1);
        done2 = 1'b0;
        checkVal("race_err", 32'(err2), 0);
        checkVal("race_busy", 32'(busy2), 0);
        tick(2);
        checkVal("race_err_late", 32'(err2), 0);

        // three-source build: invalid select, then source 2
        sel3 = 2'd3;
        start3 = 3'b111;
        tick(5);
        checkVal("badsel_busy", 32'(busy3), 0);
        start3 = '0;
        tick(2);
        sel3 = 2'd2;
        cmd3 = 6'b01_10_11;
        start3 = 3'b100;
        q3.push_back('{cyc + 2, 32'd1, 32'd2, 32'd4});
        tick(4);
        checkVal("src2_busy", 32'(busy3), 1);
        done3 = 1'b1;
        tick(1);
        done3 = 1'b0;
        tick(1);
        checkVal("src2_done", 32'(busy3), 0);

        // asynchronous reset during WAIT
        start2 = '0;
        tick(2);
        sel2 = 1'b1;
        cmd2 = 4'b1000;
        start2[1] = 1'b1;
        q2.push_back('{cyc + 2, 32'd2, 32'd1, 32'd2});
        tick(6);
        checkVal("pre_rst_busy", 32'(busy2), 1);
        checkVal("pre_rst_act", 32'(as2), 1);
        #2 rst_n = 1'b0;
        #1;
        checkVal("arst_start", 32'(so2), 0);
        checkVal("arst_cmd", 32'(co2), 0);
        checkVal("arst_act", 32'(as2), 0);
        checkVal("arst_busy", 32'(busy2), 0);
        checkVal("arst_ack", 32'(ack2), 0);
        checkVal("arst_err", 32'(err2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        checkVal("post_rst_busy", 32'(busy2), 0);

        checkVal("q2_empty", q2.size(), 0);
        checkVal("q3_empty", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
